// File: rtl/sample_dma_req_arbiter_pkg.sv
// Shared types for the sample DMA request arbiter: request record, FSM states
// and a helper that assembles a request record from its fields.
package sample_dma_req_arbiter_pkg;

    localparam int DMA_ADDR_W = 32;
    localparam int DMA_ID_W   = 6;
    localparam int DMA_LEN_W  = 8;

    typedef struct packed {
        logic [DMA_ADDR_W-1:0] addr;
        logic [DMA_ID_W-1:0]   id;
        logic [DMA_LEN_W-1:0]  len;
    } dma_req_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_t;

    function automatic dma_req_t make_req(input logic [DMA_ADDR_W-1:0] addr,
                                          input logic [DMA_ID_W-1:0]   id,
                                          input logic [DMA_LEN_W-1:0]  len);
        dma_req_t r;
        r.addr = addr;
        r.id   = id;
        r.len  = len;
        return r;
    endfunction

endpackage

// File: rtl/sample_dma_req_arbiter_if.sv
// Requester-side and bridge-side signals of the DMA request arbiter.
// master = requesters plus AXI bridge, slave = the arbiter itself.
interface sample_dma_req_arbiter_if #(
    parameter int NUM_REQ = 2
);
    import sample_dma_req_arbiter_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Handshake: every valid/done/err here is a one-cycle pulse with no ready
    // or back-pressure; the receiver must capture it in the cycle it is high.
    logic [NUM_REQ*DMA_ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DMA_ID_W-1:0]   req_id;
    logic [NUM_REQ*DMA_LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_done;
    logic [NUM_REQ-1:0]            req_err;
    logic [DMA_ADDR_W-1:0]         dma_req_addr;
    logic [DMA_ID_W-1:0]           dma_req_id;
    logic [DMA_LEN_W-1:0]          dma_req_len;
    logic                          dma_req_valid;
    logic                          dma_req_done;
    logic [IDX_W-1:0]              grant_idx;
    logic                          busy;
    logic                          timeout_err;

    modport master (
        output req_addr, req_id, req_len, req_valid, dma_req_done,
        input  req_done, req_err, dma_req_addr, dma_req_id, dma_req_len,
               dma_req_valid, grant_idx, busy, timeout_err
    );

    modport slave (
        input  req_addr, req_id, req_len, req_valid, dma_req_done,
        output req_done, req_err, dma_req_addr, dma_req_id, dma_req_len,
               dma_req_valid, grant_idx, busy, timeout_err
    );

endinterface

// File: rtl/sample_dma_req_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: returns the first set bit of pending_i
// at or after ptr_i, wrapping around.
module rr_priority_picker #(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     pending_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [2*N-1:0] doubled;
    logic [N-1:0]   rotated;
    logic [IDX_W:0] sum;

    always_comb begin
        doubled = {pending_i, pending_i};
        // rotated[k] is pending[(ptr + k) mod N]
        rotated = N'(doubled >> ptr_i);
        any_o   = |rotated;
        idx_o   = '0;
        sum     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
                if (sum >= (IDX_W+1)'(N)) begin
                    sum = sum - (IDX_W+1)'(N);
                end
                idx_o = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sample_dma_req_arbiter.sv
// Shares the single bridge DMA read-request port among NUM_REQ requesters:
// captures request pulses, grants round-robin, one outstanding request, done watchdog.
module sample_dma_req_arbiter
    import sample_dma_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     reset_n,
    sample_dma_req_arbiter_if.slave  bus,
    output arb_state_t               dbg_state_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    dma_req_t           in_req [NUM_REQ];
    dma_req_t           slot_q [NUM_REQ];
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [NUM_REQ-1:0] accept, clr_vec;
    logic [NUM_REQ-1:0] done_q, err_q;

    arb_state_t       state_q;
    logic [IDX_W-1:0] grant_q, rr_ptr_q, rr_next, pick_idx;
    logic             pick_any;
    dma_req_t         dma_q;
    logic             dma_valid_q, busy_q, timeout_q;
    logic [WD_W-1:0]  wd_q;
    logic             wd_expire, finish_now;

    rr_priority_picker #(.N(NUM_REQ)) u_picker (
        .pending_i (pending_q),
        .ptr_i     (rr_ptr_q),
        .any_o     (pick_any),
        .idx_o     (pick_idx)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            in_req[i] = make_req(bus.req_addr[DMA_ADDR_W*i +: DMA_ADDR_W],
                                 bus.req_id[DMA_ID_W*i +: DMA_ID_W],
                                 bus.req_len[DMA_LEN_W*i +: DMA_LEN_W]);
        end
    end

    // A pulse on an already-pending requester is a protocol violation and is dropped.
    assign accept     = bus.req_valid & ~pending_q;
    assign wd_expire  = WD_EN && (wd_q == WD_LAST);
    assign finish_now = (state_q == WAIT_DONE) && (bus.dma_req_done || wd_expire);
    assign clr_vec    = finish_now ? (NUM_REQ'(1) << grant_q) : '0;
    assign pending_d  = (pending_q & ~clr_vec) | accept;
    assign rr_next    = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    slot_q[i] <= in_req[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            dma_q       <= '0;
            dma_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            wd_q        <= '0;
            done_q      <= '0;
            err_q       <= '0;
        end else begin
            dma_valid_q <= 1'b0;
            done_q      <= clr_vec;
            // Bridge done wins over an expiry landing in the same cycle.
            err_q       <= (finish_now && !bus.dma_req_done) ? clr_vec : '0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_q     <= pick_idx;
                        dma_q       <= slot_q[pick_idx];
                        dma_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    rr_ptr_q <= rr_next;
                    wd_q     <= '0;
                    state_q  <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (finish_now) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                        if (!bus.dma_req_done) begin
                            timeout_q <= 1'b1;
                        end
                    end else if (wd_q != '1) begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_done      = done_q;
    assign bus.req_err       = err_q;
    assign bus.dma_req_addr  = dma_q.addr;
    assign bus.dma_req_id    = dma_q.id;
    assign bus.dma_req_len   = dma_q.len;
    assign bus.dma_req_valid = dma_valid_q;
    assign bus.grant_idx     = grant_q;
    assign bus.busy          = busy_q;
    assign bus.timeout_err   = timeout_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_sample_dma_req_arbiter.sv
// Bench for sample_dma_req_arbiter (4 requesters, 16-cycle watchdog): directed
// scenarios plus random traffic checked cycle by cycle against a rule-level model.
module tb_sample_dma_req_arbiter;
    import sample_dma_req_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    arb_state_t dbg_state;

    sample_dma_req_arbiter_if #(.NUM_REQ(N)) bus ();

    sample_dma_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // stimulus knobs
    int p_req, p_stray, resp_min, resp_max;
    bit hog0;

    // reference model: pending flags, request slots, arrival cycle, transfer bookkeeping
    bit [N-1:0]     m_pending;
    dma_req_t       m_slot [N];
    int             m_time [N];
    int             m_ptr, m_issue_t, m_resp_k, m_pulse_t, m_free_at, m_grant;
    bit             m_busy, m_pulse_err, m_timeout;
    dma_req_t       m_last;
    logic [IW-1:0]  exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_zero();
        bus.req_valid    = '0;
        bus.req_addr     = '0;
        bus.req_id       = '0;
        bus.req_len      = '0;
        bus.dma_req_done = 1'b0;
    endtask

    task automatic model_reset();
        m_pending = '0;
        for (int i = 0; i < N; i++) begin
            m_slot[i] = '0;
            m_time[i] = 0;
        end
        m_ptr = 0; m_issue_t = 0; m_resp_k = 1; m_pulse_t = -1;
        m_free_at = 0; m_grant = 0; m_busy = 0; m_pulse_err = 0;
        m_timeout = 0; m_last = '0;
        exp_q.delete();
        cyc = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_done"},    64'(bus.req_done),      64'd0);
        check_eq({tag, "_req_err"},     64'(bus.req_err),       64'd0);
        check_eq({tag, "_dma_valid"},   64'(bus.dma_req_valid), 64'd0);
        check_eq({tag, "_dma_addr"},    64'(bus.dma_req_addr),  64'd0);
        check_eq({tag, "_dma_id"},      64'(bus.dma_req_id),    64'd0);
        check_eq({tag, "_dma_len"},     64'(bus.dma_req_len),   64'd0);
        check_eq({tag, "_grant_idx"},   64'(bus.grant_idx),     64'd0);
        check_eq({tag, "_busy"},        64'(bus.busy),          64'd0);
        check_eq({tag, "_timeout_err"}, 64'(bus.timeout_err),   64'd0);
        check_eq({tag, "_state"},       64'(dbg_state),         64'(IDLE));
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        drive_zero();
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        model_reset();
    endtask

    // One clock cycle: predict and check outputs, then drive this cycle's inputs.
    // Forced requester i gets force_req with id offset by i.
    task automatic do_cycle(input logic [N-1:0] force_v, input dma_req_t force_req);
        logic [N-1:0]  exp_done, exp_err, v;
        logic          exp_valid;
        logic [IW-1:0] owner;
        int            pick;
        dma_req_t      r;
        arb_state_t    exp_state;
        @(negedge clk);
        exp_done  = '0;
        exp_err   = '0;
        exp_valid = 1'b0;
        pick      = -1;

        // completion pulse scheduled for this cycle
        if (m_pulse_t == cyc && exp_q.size() > 0) begin
            owner = exp_q.pop_front();
            exp_done[owner] = 1'b1;
            exp_err[owner]  = m_pulse_err;
            m_pending[owner] = 1'b0;
            m_busy    = 1'b0;
            m_free_at = cyc + 1;
            if (m_pulse_err) m_timeout = 1'b1;
            m_pulse_t = -1;
        end

        // a grant is issued two cycles after the request arrives, once the port is free
        if (!m_busy && cyc >= m_free_at) begin
            for (int k = 0; k < N; k++) begin
                if (pick < 0 && m_pending[(m_ptr + k) % N] && m_time[(m_ptr + k) % N] <= cyc - 2)
                    pick = (m_ptr + k) % N;
            end
        end
        if (pick >= 0) begin
            exp_valid = 1'b1;
            m_busy    = 1'b1;
            m_issue_t = cyc;
            m_ptr     = (pick + 1) % N;
            m_last    = m_slot[pick];
            m_grant   = pick;
            m_resp_k  = $urandom_range(resp_max, resp_min);
            exp_q.push_back(IW'(pick));
        end
        exp_state = exp_valid ? ISSUE : (m_busy ? WAIT_DONE : IDLE);

        check_eq("req_done",      64'(bus.req_done),      64'(exp_done));
        check_eq("req_err",       64'(bus.req_err),       64'(exp_err));
        check_eq("dma_req_valid", 64'(bus.dma_req_valid), 64'(exp_valid));
        check_eq("dma_req_addr",  64'(bus.dma_req_addr),  64'(m_last.addr));
        check_eq("dma_req_id",    64'(bus.dma_req_id),    64'(m_last.id));
        check_eq("dma_req_len",   64'(bus.dma_req_len),   64'(m_last.len));
        check_eq("grant_idx",     64'(bus.grant_idx),     64'(m_grant));
        check_eq("busy",          64'(bus.busy),          64'(m_busy));
        check_eq("timeout_err",   64'(bus.timeout_err),   64'(m_timeout));
        check_eq("state",         64'(dbg_state),         64'(exp_state));

        // bridge response, or stray done outside the waiting window
        bus.dma_req_done = 1'b0;
        if (m_busy && cyc > m_issue_t && m_pulse_t < 0) begin
            if (cyc == m_issue_t + m_resp_k) begin
                bus.dma_req_done = 1'b1;
                m_pulse_t   = cyc + 1;
                m_pulse_err = 1'b0;
            end else if (cyc == m_issue_t + TO) begin
                m_pulse_t   = cyc + 1;
                m_pulse_err = 1'b1;
            end
        end else begin
            bus.dma_req_done = ($urandom_range(99, 0) < p_stray);
        end

        // requester pulses
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (force_v[i]) begin
                v[i] = 1'b1;
                r = force_req;
                r.id = force_req.id + 6'(i);
            end else begin
                v[i] = ($urandom_range(99, 0) < p_req) || (hog0 && i == 0 && exp_done[0]);
                r = make_req($urandom(), 6'($urandom_range(63, 0)), 8'($urandom_range(255, 0)));
            end
            bus.req_addr[32*i +: 32] = r.addr;
            bus.req_id[6*i +: 6]     = r.id;
            bus.req_len[8*i +: 8]    = r.len;
            if (v[i] && !m_pending[i]) begin
                m_pending[i] = 1'b1;
                m_time[i]    = cyc;
                m_slot[i]    = r;
            end
        end
        bus.req_valid = v;
        cyc++;
    endtask

    task automatic run_idle(input int n);
        for (int c = 0; c < n; c++) do_cycle('0, '0);
    endtask

    initial begin
        bit found;
        reset_n = 1'b1;
        drive_zero();
        p_req = 0; p_stray = 0; resp_min = 1; resp_max = 1; hog0 = 0;
        #1;
        apply_reset();

        // single request with fixed fields, bridge answers after 3 cycles
        resp_min = 3; resp_max = 3;
        do_cycle(4'b0001, make_req(32'h1000_0000, 6'd5, 8'd64));
        run_idle(10);

        // simultaneous requests from 0 and 1, two rounds
        apply_reset();
        resp_min = 1; resp_max = 4;
        for (int r = 0; r < 2; r++) begin
            do_cycle(4'b0011, make_req(32'h2000_0040 + 32'(r), 6'd10, 8'd8));
            run_idle(20);
        end

        // fairness: everyone pending, requester 0 re-requests on each done
        apply_reset();
        hog0 = 1; resp_min = 2; resp_max = 5;
        do_cycle(4'b1111, make_req(32'h3000_0000, 6'd20, 8'd16));
        run_idle(60);
        hog0 = 0;
        run_idle(12);

        // watchdog: no response at all, then a response on the last allowed cycle
        apply_reset();
        resp_min = TO + 1; resp_max = TO + 1;
        do_cycle(4'b0100, make_req(32'h4000_0000, 6'd33, 8'd1));
        run_idle(25);
        resp_min = TO; resp_max = TO;
        do_cycle(4'b0100, make_req(32'h4000_1000, 6'd34, 8'd2));
        run_idle(25);

        // protocol violations: re-pulse while pending, stray dones everywhere
        p_stray = 100; resp_min = 3; resp_max = 3;
        do_cycle(4'b0010, make_req(32'h0000_1000, 6'd7, 8'd4));
        do_cycle(4'b0010, make_req(32'h0000_DEAD, 6'd9, 8'd99));
        run_idle(15);

        // random traffic
        p_req = 15; p_stray = 20; resp_min = 1; resp_max = TO + 3;
        run_idle(1500);

        // reset asserted while waiting for done
        p_req = 30; resp_min = 6; resp_max = TO;
        found = 0;
        for (int k = 0; k < 300 && !found; k++) begin
            do_cycle('0, '0);
            if (m_busy && (cyc - 1) >= m_issue_t + 2 && m_pulse_t < 0) found = 1;
        end
        check_eq("reached_wait_done", 64'(found), 64'd1);
        #2;
        reset_n = 1'b0;
        drive_zero();
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        p_req = 15; p_stray = 20; resp_min = 1; resp_max = TO + 3;
        run_idle(400);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
